// File: rtl/usb_crc16_tx_ctrl.sv
// USB data-packet transmit sequencer: PID byte, payload pass-through with
// CRC16 engine feed, then the 16-bit CRC appended LSB-first.
module usb_crc16_tx_ctrl #(
    parameter bit INVERT_CRC = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        pkt_start,
    input  logic [3:0]  pkt_pid,
    input  logic        pkt_zero_len,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  crc_data,
    output logic        crc_en,
    output logic        crc_clr,
    input  logic [15:0] crc_value,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_PID, S_DATA, S_SETTLE, S_CRC_LO, S_CRC_HI
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  pid_q, pid_d;
    logic        zero_len_q, zero_len_d;
    logic [15:0] hold_q, hold_d;
    logic        done_q, done_d;
    logic [15:0] crc_tx;
    logic        kill;

    assign crc_tx = INVERT_CRC ? ~hold_q : hold_q;
    assign kill   = abort && (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            pid_q      <= 4'h0;
            zero_len_q <= 1'b0;
            hold_q     <= 16'h0000;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            zero_len_q <= zero_len_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (pkt_start) state_d = S_PID;
            S_PID:    if (tx_ready) state_d = zero_len_q ? S_SETTLE : S_DATA;
            S_DATA:   if (in_valid && tx_ready && in_last) state_d = S_SETTLE;
            S_SETTLE: state_d = S_CRC_LO;
            S_CRC_LO: if (tx_ready) state_d = S_CRC_HI;
            S_CRC_HI: if (tx_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // abort outranks every transition out of a busy state
        if (kill) state_d = S_IDLE;
    end

    always_comb begin
        pid_d      = pid_q;
        zero_len_d = zero_len_q;
        hold_d     = hold_q;
        done_d     = (state_q == S_CRC_HI) && tx_ready && !kill;
        if (state_q == S_IDLE && pkt_start) begin
            pid_d      = pkt_pid;
            zero_len_d = pkt_zero_len;
        end
        // engine result is stable one cycle after the last crc_en
        if (state_q == S_SETTLE && !kill) hold_d = crc_value;
    end

    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        in_ready = 1'b0;
        crc_data = 8'h00;
        crc_en   = 1'b0;
        crc_clr  = 1'b0;
        busy     = (state_q != S_IDLE);
        done     = done_q;
        unique case (state_q)
            S_IDLE:   crc_clr = pkt_start;
            S_PID: begin
                tx_valid = 1'b1;
                tx_data  = {~pid_q, pid_q};
            end
            S_DATA: begin
                tx_data  = in_data;
                tx_valid = in_valid;
                in_ready = tx_ready;
                crc_data = in_data;
                crc_en   = in_valid && tx_ready;
            end
            S_SETTLE: ;
            S_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = crc_tx[7:0];
            end
            S_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = crc_tx[15:8];
            end
            default: ;
        endcase
        if (kill) begin
            tx_valid = 1'b0;
            in_ready = 1'b0;
            crc_en   = 1'b0;
            crc_clr  = 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_crc16_tx_ctrl.sv
// Directed bench for usb_crc16_tx_ctrl: scoreboard queues of expected tx and
// CRC-engine bytes, drained by a negedge monitor.
module tb_usb_crc16_tx_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        pkt_start, pkt_zero_len, abort;
    logic [3:0]  pkt_pid;
    logic [7:0]  in_data;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  crc_data;
    logic        crc_en, crc_clr;
    logic [15:0] crc_value;
    logic        busy, done;

    usb_crc16_tx_ctrl #(.INVERT_CRC(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .pkt_start(pkt_start), .pkt_pid(pkt_pid),
        .pkt_zero_len(pkt_zero_len), .abort(abort), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .crc_data(crc_data), .crc_en(crc_en), .crc_clr(crc_clr),
        .crc_value(crc_value), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] crc_q[$];
    logic [7:0] pay [0:7];

    // CRC engine stub: either a fixed value or a simple mixing register
    bit          stub_fixed = 1'b1;
    logic [15:0] fixed_val = 16'h0000;
    logic [15:0] crc_reg = 16'h0000;

    function automatic logic [15:0] mix(input logic [15:0] r, input logic [7:0] d);
        return {r[7:0] ^ d, r[15:8]} + 16'h1357;
    endfunction

    always @(posedge clk) begin
        if (crc_clr) crc_reg <= 16'hFFFF;
        else if (crc_en) crc_reg <= mix(crc_reg, crc_data);
    end
    assign crc_value = stub_fixed ? fixed_val : crc_reg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    bit         prev_stall = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge clk) begin
        if (n_rst) begin
            if (prev_stall && !abort)
                chk("tx_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_d}));
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    vec++; err++;
                    $error("FAIL tx_extra: got %h want none", tx_data);
                end else chk("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            end
            if (crc_en) begin
                if (crc_q.size() == 0) begin
                    vec++; err++;
                    $error("FAIL crc_extra: got %h want none", crc_data);
                end else chk("crc_byte", 32'(crc_data), 32'(crc_q.pop_front()));
            end
            if (done) begin
                done_cnt++;
                chk("done_busy", 32'(busy), 32'(0));
            end
            if (crc_clr) clr_cnt++;
        end
        prev_stall = n_rst && tx_valid && !tx_ready && !abort;
        prev_d     = tx_data;
    end

    // Drives one packet; abort_at >= 1 aborts once that many bytes are accepted.
    task automatic run_pkt(input logic [3:0] pid, input int n, input int stall,
                           input logic [7:0] vpat, input int abort_at,
                           input bit spam, input bit abort_first);
        int pi = 0, sc = 0, g = 0, cyc = 0;
        bit held = 0, fin = 0, aborted = 0;
        int done_base, clr_base;
        logic [15:0] ec;
        ec = stub_fixed ? fixed_val : 16'hFFFF;
        tx_q.push_back({~pid, pid});
        for (int k = 0; k < n; k++) begin
            if (abort_at < 0 || k < abort_at) begin
                tx_q.push_back(pay[k]);
                crc_q.push_back(pay[k]);
                if (!stub_fixed) ec = mix(ec, pay[k]);
            end
        end
        if (abort_at < 0) begin
            tx_q.push_back(~ec[7:0]);
            tx_q.push_back(~ec[15:8]);
        end
        done_base = done_cnt;
        clr_base  = clr_cnt;
        pkt_pid = pid; pkt_zero_len = (n == 0); pkt_start = 1'b1;
        abort = abort_first;
        tx_ready = 1'b0;
        step();
        pkt_start = 1'b0; abort = 1'b0;
        chk("busy_start", 32'(busy), 32'(1));
        while (!fin && cyc < 300) begin
            in_valid  = (pi < n) && (vpat[g % 8] || held);
            in_data   = (pi < n) ? pay[pi] : 8'h00;
            in_last   = (pi == n - 1);
            tx_ready  = (sc >= stall);
            pkt_start = spam && busy;
            abort     = (abort_at >= 0) && (pi == abort_at) && !aborted;
            @(negedge clk);
            if (in_ready)
                chk("data_pass", 32'({tx_valid, tx_data}), 32'({in_valid, in_data}));
            if (abort) begin
                chk("abort_out", 32'({tx_valid, in_ready, crc_en, crc_clr}), 32'(4'b0001));
                aborted = 1'b1;
            end
            if (in_valid && in_ready) begin pi++; held = 1'b0; end
            else held = in_valid;
            if (tx_valid) sc = tx_ready ? 0 : sc + 1;
            if (done) fin = 1'b1;
            step();
            abort = 1'b0;
            g++; cyc++;
            if (aborted && !fin) begin
                chk("abort_idle", 32'({busy, tx_valid}), 32'(0));
                fin = 1'b1;
            end
        end
        pkt_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; tx_ready = 1'b1;
        chk("pkt_finished", 32'(fin), 32'(1));
        repeat (3) step();
        chk("tx_q_empty", 32'(tx_q.size()), 32'(0));
        chk("crc_q_empty", 32'(crc_q.size()), 32'(0));
        chk("done_count", 32'(done_cnt - done_base), 32'(aborted ? 0 : 1));
        chk("clr_count", 32'(clr_cnt - clr_base), 32'(aborted ? 2 : 1));
        tx_q.delete();
        crc_q.delete();
    endtask

    initial begin
        n_rst = 1'b0; pkt_start = 1'b0; pkt_pid = 4'h0; pkt_zero_len = 1'b0;
        abort = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        tx_ready = 1'b0;
        step(); step();
        @(negedge clk);
        chk("reset_outs", 32'({tx_valid, tx_data, in_ready, crc_en, crc_clr, busy, done}), 32'(0));
        step();
        n_rst = 1'b1;
        step();

        // DATA0, fixed engine value -> C3 01 02 03 5E B3
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        stub_fixed = 1'b1; fixed_val = 16'h4CA1;
        run_pkt(4'h3, 3, 0, 8'hFF, -1, 1'b0, 1'b0);

        // zero-length -> 4B 00 00
        fixed_val = 16'hFFFF;
        run_pkt(4'hB, 0, 0, 8'hFF, -1, 1'b0, 1'b0);

        // backpressure: two stalled cycles per byte
        fixed_val = 16'h4CA1;
        run_pkt(4'h3, 3, 2, 8'hFF, -1, 1'b0, 1'b0);

        // source gaps, pkt_start hammered while busy, mixing engine
        stub_fixed = 1'b0;
        pay[0] = 8'hA5; pay[1] = 8'h5A; pay[2] = 8'h00; pay[3] = 8'hFF; pay[4] = 8'h3C;
        run_pkt(4'hC, 5, 0, 8'b1110_1001, -1, 1'b1, 1'b0);

        // abort after two payload bytes
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
        run_pkt(4'h3, 4, 0, 8'hFF, 2, 1'b0, 1'b0);

        // follow-up packet with fresh CRC; abort in IDLE alongside pkt_start
        pay[0] = 8'h77; pay[1] = 8'h88;
        run_pkt(4'h2, 2, 1, 8'hFF, -1, 1'b0, 1'b1);

        // reset while in CRC_LO
        stub_fixed = 1'b1; fixed_val = 16'h1234;
        tx_q.push_back(8'hA5);
        pkt_pid = 4'h5; pkt_zero_len = 1'b1; pkt_start = 1'b1; tx_ready = 1'b1;
        step();
        pkt_start = 1'b0;
        step();
        step();
        tx_ready = 1'b0; n_rst = 1'b0; pkt_start = 1'b1;
        @(negedge clk);
        chk("pre_reset_busy", 32'({busy, tx_valid, tx_data}), 32'({2'b11, 8'hCB}));
        step();
        n_rst = 1'b1; pkt_start = 1'b0;
        @(negedge clk);
        chk("mid_reset_outs", 32'({tx_valid, tx_data, in_ready, crc_en, crc_clr, busy, done}), 32'(0));
        step();
        tx_ready = 1'b1;
        repeat (4) step();
        chk("reset_tx_q", 32'(tx_q.size()), 32'(0));
        chk("reset_idle", 32'({busy, tx_valid}), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
